interp_serializer_10x: RTL and testbench
========================================

Name: interp_serializer_10x

Overview:
- Downstream companion of the 10x interpolator.
- Captures the ten parallel interpolated samples (y0..y9) when the interpolator signals end of stage. Replays them one per 480 kHz enable as a single sample stream for the PDM modulator.
- Ping-pong buffered: the next burst loads while the current burst drains.
- Reports underrun and overrun conditions.

Parameters:
- WIDTH, 8, sample width in bits (unsigned).
- MIDSCALE, 128, filler value emitted on underrun; must fit in WIDTH bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- clk_en_10x  in  1  single-cycle output-rate tick (480 kHz).
- load  in  1  single-cycle pulse; the interpolator's end_stage; captures sample_y0..sample_y9.
- sample_y0 .. sample_y9  in  WIDTH each  burst samples; y0 is emitted first.
- clr_flags  in  1  clears the sticky underrun/overrun flags.
- sample_out  out  WIDTH  current output sample, registered.
- sample_valid  out  1  one-cycle pulse, the cycle after the tick that updated sample_out.
- frame_start  out  1  one-cycle pulse coincident with sample_valid when the emitted sample is y0.
- underrun  out  1  sticky; a burst boundary was reached with no pending burst.
- overrun  out  1  sticky; a pending burst was overwritten before being consumed.
- busy  out  1  high in RUN or STARVED.

Behaviour:
- Reset values:
  - sample_out = MIDSCALE.
  - sample_valid, frame_start, underrun, overrun, busy = 0.
  - state = IDLE, idx = 0, pend_valid = 0.
  - Both banks are undefined until loaded.
- Reset asserted mid-operation discards both banks and returns to IDLE on the next edge.
- Storage:
  - pend[0..9] is the pending bank; pend_valid flags it.
  - act[0..9] is the active bank.
  - idx (0..9) points at the next active sample.
- load:
  - pend <= y0..y9 and pend_valid <= 1.
  - If pend_valid is already 1 and the same cycle is not a consuming tick, set overrun. The new data overwrites (newest wins).
- Consuming tick: clk_en_10x high with idx == 0 and pend_valid == 1, in any state.
  - act <= pend.
  - sample_out <= pend[0], idx <= 1.
  - sample_valid and frame_start pulse next cycle.
  - state <= RUN.
  - pend_valid <= 0, unless load is high in the same cycle. In that case pend takes the new burst, pend_valid stays 1, and no overrun is raised.
- RUN tick with idx in 1..9:
  - sample_out <= act[idx].
  - idx <= idx+1, wrapping 9 -> 0.
  - sample_valid pulses.
- RUN tick with idx == 0 and pend_valid == 0:
  - Set underrun; state <= STARVED.
  - Emit filler with sample_valid pulsing; frame_start stays 0.
- STARVED:
  - Every tick emits filler with sample_valid = 1; idx stays 0.
  - Exits to RUN via a consuming tick.
- IDLE:
  - Ticks without a pending burst produce nothing: sample_valid = 0 and sample_out unchanged.
  - No underrun is flagged before the first burst.
- Filler value: MIDSCALE (see Optional Feature).
- Latency: the tick at cycle N gives sample_out / sample_valid at cycle N+1.
- Sample-to-load latency: y0 of a burst appears at the first tick at least one cycle after load.
- Flag clearing:
  - clr_flags clears both sticky flags.
  - If a set condition occurs in the same cycle, set wins.
- Inputs are only sampled on load; values outside load cycles are ignored.
- Ticks and loads are assumed never to occur in every cycle. Back-to-back ticks must still be handled correctly.

Optional Feature:
- Macro: INTERP_SER_UNDERRUN_HOLD_EN.
- Defined: filler on underrun is the last emitted sample (sample_out holds its value), giving a zero-order hold.
- Undefined: filler is MIDSCALE.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then 20 ticks without load -> sample_out = 128, sample_valid never asserted, busy = 0, flags = 0.
- Load y0..y9 = 10,20,..,100, then 10 ticks spaced 100 clk -> sample_out 10,20,..,100 in order, each one cycle after its tick. frame_start only with 10. Next tick -> underrun = 1, sample_out = 128 (or 100 with HOLD_EN), sample_valid = 1.
- Steady stream: load every 1000 clk, tick every 100 clk, loads offset to land mid-burst, 50 bursts -> contiguous output equal to concatenated bursts, no flags.
- Two loads (bursts A, B) before the first tick, then 10 ticks -> overrun = 1, output is burst B. Then clr_flags -> overrun = 0.
- load and the idx==0 tick in the same cycle, with pend_valid = 1 -> old pending burst emitted, new burst pending, overrun = 0, next boundary continues seamlessly.
- Assert reset at idx = 5 mid-burst -> next cycle all outputs return to reset values. Subsequent ticks produce no valid until a new load.

Source files
------------

// File: rtl/interp_serializer_10x_if.sv
// Burst-in / stream-out bus between the 10x interpolator, the serializer and the PDM modulator.
// The master drives a ten-sample burst with a load strobe; the slave returns the serial stream.
interface interp_serializer_10x_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] sample_y0;
    logic [WIDTH-1:0] sample_y1;
    logic [WIDTH-1:0] sample_y2;
    logic [WIDTH-1:0] sample_y3;
    logic [WIDTH-1:0] sample_y4;
    logic [WIDTH-1:0] sample_y5;
    logic [WIDTH-1:0] sample_y6;
    logic [WIDTH-1:0] sample_y7;
    logic [WIDTH-1:0] sample_y8;
    logic [WIDTH-1:0] sample_y9;
    logic [WIDTH-1:0] sample_out;
    logic             sample_valid;
    logic             frame_start;

    modport master (
        output load, sample_y0, sample_y1, sample_y2, sample_y3, sample_y4,
               sample_y5, sample_y6, sample_y7, sample_y8, sample_y9,
        input  sample_out, sample_valid, frame_start
    );

    modport slave (
        input  load, sample_y0, sample_y1, sample_y2, sample_y3, sample_y4,
               sample_y5, sample_y6, sample_y7, sample_y8, sample_y9,
        output sample_out, sample_valid, frame_start
    );
endinterface

// File: rtl/interp_serializer_10x.sv
// Ping-pong serializer: captures ten interpolated samples per load and replays one per 480 kHz tick.
// Define INTERP_SER_UNDERRUN_HOLD_EN to repeat the last sample on underrun instead of MIDSCALE.
module interp_serializer_10x #(
    parameter int WIDTH    = 8,
    parameter int MIDSCALE = 128
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_en_10x,
    input  logic                     clr_flags,
    interp_serializer_10x_if.slave   bus,
    output logic                     underrun,
    output logic                     overrun,
    output logic                     busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] STARVED = 2'd2;

    localparam logic [WIDTH-1:0] FILLER = WIDTH'(MIDSCALE);
    localparam logic [3:0]       LAST   = 4'd9;

    logic [1:0]       state;
    logic [3:0]       idx;
    logic             pend_valid;
    logic [WIDTH-1:0] pend [10];
    logic [WIDTH-1:0] act  [10];
    logic [WIDTH-1:0] sample_out;
    logic             sample_valid;
    logic             frame_start;

    logic consume;
    logic advance;
    logic starve;
    logic set_overrun;
    logic set_underrun;

    always_comb begin
        consume      = clk_en_10x && (idx == 4'd0) && pend_valid;
        advance      = clk_en_10x && (state == RUN) && (idx != 4'd0);
        // Boundary or starved tick with nothing pending; IDLE stays silent.
        starve       = clk_en_10x && (state != IDLE) && (idx == 4'd0) && !pend_valid;
        set_overrun  = bus.load && pend_valid && !consume;
        set_underrun = starve && (state == RUN);
    end

    // NOTE: sample banks carry no reset; pend_valid and the FSM already make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (bus.load) begin
            pend[0] <= bus.sample_y0;
            pend[1] <= bus.sample_y1;
            pend[2] <= bus.sample_y2;
            pend[3] <= bus.sample_y3;
            pend[4] <= bus.sample_y4;
            pend[5] <= bus.sample_y5;
            pend[6] <= bus.sample_y6;
            pend[7] <= bus.sample_y7;
            pend[8] <= bus.sample_y8;
            pend[9] <= bus.sample_y9;
        end
        if (consume) begin
            act <= pend;
        end
    end

    // NOTE: non-blocking assignments throughout, so act/pend swap reads the pre-edge pend contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= 4'd0;
            pend_valid   <= 1'b0;
            sample_out   <= FILLER;
            sample_valid <= 1'b0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_start  <= 1'b0;

            if (bus.load) begin
                pend_valid <= 1'b1;
            end

            if (consume) begin
                sample_out   <= pend[0];
                idx          <= 4'd1;
                sample_valid <= 1'b1;
                frame_start  <= 1'b1;
                state        <= RUN;
                if (!bus.load) begin
                    pend_valid <= 1'b0;
                end
            end else if (advance) begin
                sample_out   <= act[idx];
                idx          <= (idx == LAST) ? 4'd0 : idx + 4'd1;
                sample_valid <= 1'b1;
            end else if (starve) begin
`ifdef INTERP_SER_UNDERRUN_HOLD_EN
                sample_out   <= sample_out;
`else
                sample_out   <= FILLER;
`endif
                sample_valid <= 1'b1;
                state        <= STARVED;
            end

            // Set has priority over clear on both sticky flags.
            if (set_underrun) begin
                underrun <= 1'b1;
            end else if (clr_flags) begin
                underrun <= 1'b0;
            end

            if (set_overrun) begin
                overrun <= 1'b1;
            end else if (clr_flags) begin
                overrun <= 1'b0;
            end
        end
    end

    assign busy             = (state == RUN) || (state == STARVED);
    assign bus.sample_out   = sample_out;
    assign bus.sample_valid = sample_valid;
    assign bus.frame_start  = frame_start;

endmodule

// File: tb/tb_interp_serializer_10x.sv
// Directed bench for interp_serializer_10x: idle ticks, single burst, streaming, overrun,
// same-cycle load/consume and mid-burst reset, all against hand-computed values.
module tb_interp_serializer_10x;

    localparam int WIDTH = 8;

`ifdef INTERP_SER_UNDERRUN_HOLD_EN
    localparam logic [7:0] FILL_AFTER_RAMP = 8'd100;
`else
    localparam logic [7:0] FILL_AFTER_RAMP = 8'd128;
`endif

    logic clk;
    logic reset;
    logic clk_en_10x;
    logic clr_flags;
    logic underrun;
    logic overrun;
    logic busy;

    int n_checks;
    int n_errors;

    interp_serializer_10x_if #(.WIDTH(WIDTH)) bus ();

    interp_serializer_10x #(.WIDTH(WIDTH), .MIDSCALE(128)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_en_10x (clk_en_10x),
        .clr_flags  (clr_flags),
        .bus        (bus),
        .underrun   (underrun),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_burst(input logic [7:0] v [10]);
        bus.sample_y0 = v[0];
        bus.sample_y1 = v[1];
        bus.sample_y2 = v[2];
        bus.sample_y3 = v[3];
        bus.sample_y4 = v[4];
        bus.sample_y5 = v[5];
        bus.sample_y6 = v[6];
        bus.sample_y7 = v[7];
        bus.sample_y8 = v[8];
        bus.sample_y9 = v[9];
    endtask

    task automatic do_load(input logic [7:0] v [10]);
        set_burst(v);
        bus.load = 1'b1;
        cycles(1);
        bus.load = 1'b0;
        bus.sample_y0 = 8'hxx;
    endtask

    task automatic do_tick();
        clk_en_10x = 1'b1;
        cycles(1);
        clk_en_10x = 1'b0;
    endtask

    function automatic logic [7:0] stream_val(input int b, input int i);
        return 8'((b * 7 + i * 13 + 1) & 255);
    endfunction

    function automatic logic [7:0] burst_val(input int tag, input int i);
        return 8'(tag * 16 + i);
    endfunction

    logic [7:0] ramp [10];
    logic [7:0] buf_a [10];
    logic [7:0] buf_b [10];

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        reset      = 1'b1;
        clk_en_10x = 1'b0;
        clr_flags  = 1'b0;
        bus.load   = 1'b0;
        for (int i = 0; i < 10; i++) ramp[i] = 8'(10 * (i + 1));
        set_burst(ramp);
        cycles(2);
        reset = 1'b0;

        // Reset state
        check("rst_out",   bus.sample_out, 128);
        check("rst_valid", bus.sample_valid, 0);
        check("rst_frame", bus.frame_start, 0);
        check("rst_busy",  busy, 0);
        check("rst_flags", {underrun, overrun}, 0);

        // Twenty ticks with nothing loaded: silence, no underrun
        for (int k = 0; k < 20; k++) begin
            do_tick();
            check("idle_valid", bus.sample_valid, 0);
            check("idle_out",   bus.sample_out, 128);
            cycles(2);
        end
        check("idle_busy",  busy, 0);
        check("idle_flags", {underrun, overrun}, 0);

        // Single ramp burst 10..100, ticks spaced 100 clocks
        do_load(ramp);
        cycles(3);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            check("ramp_out",   bus.sample_out, 10 * (i + 1));
            check("ramp_valid", bus.sample_valid, 1);
            check("ramp_frame", bus.frame_start, (i == 0) ? 1 : 0);
            check("ramp_busy",  busy, 1);
            cycles(1);
            check("ramp_pulse", bus.sample_valid, 0);
            cycles(98);
        end
        check("ramp_noflag", {underrun, overrun}, 0);

        // Burst boundary with nothing pending: underrun and filler
        do_tick();
        check("ur_flag",  underrun, 1);
        check("ur_out",   bus.sample_out, FILL_AFTER_RAMP);
        check("ur_valid", bus.sample_valid, 1);
        check("ur_frame", bus.frame_start, 0);
        cycles(5);
        do_tick();
        check("starved_out",   bus.sample_out, FILL_AFTER_RAMP);
        check("starved_valid", bus.sample_valid, 1);
        check("starved_busy",  busy, 1);
        clr_flags = 1'b1;
        cycles(1);
        clr_flags = 1'b0;
        check("ur_clear", underrun, 0);

        // Steady stream: 50 bursts, load lands after the fifth tick of each burst
        for (int i = 0; i < 10; i++) buf_a[i] = stream_val(0, i);
        do_load(buf_a);
        for (int k = 0; k < 500; k++) begin
            int b;
            int i;
            b = k / 10;
            i = k % 10;
            if (i == 5 && b < 49) begin
                for (int j = 0; j < 10; j++) buf_a[j] = stream_val(b + 1, j);
                do_load(buf_a);
                cycles(98);
            end else begin
                cycles(99);
            end
            do_tick();
            check("stream_out",   bus.sample_out, stream_val(b, i));
            check("stream_valid", bus.sample_valid, 1);
            check("stream_frame", bus.frame_start, (i == 0) ? 1 : 0);
        end
        check("stream_flags", {underrun, overrun}, 0);

        // Two loads before the boundary tick: overrun, newest burst wins
        for (int i = 0; i < 10; i++) begin
            buf_a[i] = burst_val(10, i);
            buf_b[i] = burst_val(11, i);
        end
        cycles(10);
        do_load(buf_a);
        cycles(3);
        do_load(buf_b);
        check("ovr_flag", overrun, 1);
        cycles(3);
        for (int i = 0; i < 10; i++) begin
            do_tick();
            check("ovr_out", bus.sample_out, burst_val(11, i));
            cycles(20);
        end
        check("ovr_sticky", overrun, 1);
        check("ovr_no_ur",  underrun, 0);
        clr_flags = 1'b1;
        cycles(1);
        clr_flags = 1'b0;
        check("ovr_clear", overrun, 0);

        // Load coinciding with the consuming tick: seamless C then D, no overrun
        for (int i = 0; i < 10; i++) begin
            buf_a[i] = burst_val(12, i);
            buf_b[i] = burst_val(13, i);
        end
        do_load(buf_a);
        cycles(5);
        set_burst(buf_b);
        bus.load   = 1'b1;
        clk_en_10x = 1'b1;
        cycles(1);
        bus.load   = 1'b0;
        clk_en_10x = 1'b0;
        check("same_out",   bus.sample_out, burst_val(12, 0));
        check("same_frame", bus.frame_start, 1);
        check("same_ovr",   overrun, 0);
        for (int k = 1; k < 20; k++) begin
            cycles(15);
            do_tick();
            check("same_seq", bus.sample_out, (k < 10) ? burst_val(12, k) : burst_val(13, k - 10));
            check("same_seq_frame", bus.frame_start, (k == 10) ? 1 : 0);
        end
        check("same_flags", {underrun, overrun}, 0);

        // Mid-burst reset at idx 5 with a pending burst and overrun flagged
        for (int i = 0; i < 10; i++) buf_a[i] = burst_val(14, i);
        do_load(buf_a);
        cycles(2);
        for (int i = 0; i < 5; i++) begin
            do_tick();
            check("pre_rst_out", bus.sample_out, burst_val(14, i));
            cycles(4);
        end
        do_load(buf_a);
        do_load(buf_a);
        check("pre_rst_ovr", overrun, 1);
        reset      = 1'b1;
        clk_en_10x = 1'b1;
        cycles(1);
        reset      = 1'b0;
        clk_en_10x = 1'b0;
        check("mid_rst_out",   bus.sample_out, 128);
        check("mid_rst_valid", bus.sample_valid, 0);
        check("mid_rst_frame", bus.frame_start, 0);
        check("mid_rst_busy",  busy, 0);
        check("mid_rst_flags", {underrun, overrun}, 0);
        for (int k = 0; k < 5; k++) begin
            cycles(3);
            do_tick();
            check("post_rst_valid", bus.sample_valid, 0);
            check("post_rst_ur",    underrun, 0);
        end
        for (int i = 0; i < 10; i++) buf_b[i] = burst_val(15, i);
        do_load(buf_b);
        cycles(1);
        do_tick();
        check("reload_out",   bus.sample_out, burst_val(15, 0));
        check("reload_frame", bus.frame_start, 1);
        check("reload_busy",  busy, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
